// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word alignment search on control-token runs,
// then per-character decode into DE, pixel byte and control value.
module tmds_channel_decoder #(
  parameter int TOKEN_RUN      = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic [9:0] tmds_word,
  output logic       de,
  output logic [7:0] data,
  output logic [1:0] ctl,
  output logic       locked,
  output logic [3:0] bit_offset
);

  localparam int RW = $clog2(TOKEN_RUN + 1);
  localparam int SW = $clog2(SEARCH_TIMEOUT);
  localparam int LW = $clog2(LOSS_TIMEOUT);

  localparam logic [RW-1:0] RUN_MAX  = RW'(TOKEN_RUN);
  localparam logic [RW-1:0] RUN_LAST = RW'(TOKEN_RUN - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(SEARCH_TIMEOUT - 1);
  localparam logic [LW-1:0] L_LAST   = LW'(LOSS_TIMEOUT - 1);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state;
  logic [19:0]   hist;
  logic [RW-1:0] run_cnt;
  logic [RW-1:0] run_nxt;
  logic [SW-1:0] s_tmr;
  logic [LW-1:0] l_tmr;

  logic [9:0]    aw;
  logic          is_tok;
  logic [1:0]    tok_val;
  logic          run_hit;
  logic [7:0]    q;
  logic [7:0]    dec;

  // Two-word window; the character may straddle a word boundary
  assign aw = 10'(hist >> bit_offset);

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'd0;
    unique case (1'b1)
      aw == TOK_00: tok_val = 2'd0;
      aw == TOK_01: tok_val = 2'd1;
      aw == TOK_10: tok_val = 2'd2;
      aw == TOK_11: tok_val = 2'd3;
      default:      is_tok  = 1'b0;
    endcase
  end

  assign q   = aw[9] ? ~aw[7:0] : aw[7:0];
  assign dec = {q[7:1] ^ q[6:0] ^ {7{~aw[8]}}, q[0]};

  // Hit: this edge completes or extends a full token run
  assign run_hit = is_tok && (run_cnt >= RUN_LAST);

  always_comb begin
    run_nxt = '0;
    if (run_hit)
      run_nxt = RUN_MAX;
    else if (is_tok)
      run_nxt = run_cnt + RW'(1);
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      hist       <= '0;
      state      <= SEARCH;
      bit_offset <= '0;
      s_tmr      <= '0;
      l_tmr      <= '0;
      run_cnt    <= '0;
      de         <= 1'b0;
      data       <= '0;
      ctl        <= '0;
    end else begin
      hist    <= {tmds_word, hist[19:10]};
      run_cnt <= run_nxt;

      unique case (state)
        SEARCH: begin
          if (run_hit) begin
            state <= LOCKED;
            s_tmr <= '0;
            l_tmr <= '0;
          end else if (s_tmr == S_LAST) begin
            bit_offset <= (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
            s_tmr      <= '0;
            run_cnt    <= '0;
          end else begin
            s_tmr <= s_tmr + SW'(1);
          end
        end
        LOCKED: begin
          if (run_hit) begin
            l_tmr <= '0;
          end else if (l_tmr == L_LAST) begin
            state   <= SEARCH;
            l_tmr   <= '0;
            s_tmr   <= '0;
            run_cnt <= '0;
          end else begin
            l_tmr <= l_tmr + LW'(1);
          end
        end
        default: state <= SEARCH;
      endcase

      if (state == LOCKED) begin
        if (is_tok) begin
          de   <= 1'b0;
          data <= '0;
          ctl  <= tok_val;
        end else begin
          de   <= 1'b1;
          data <= dec;
        end
      end else begin
        de   <= 1'b0;
        data <= '0;
        ctl  <= '0;
      end
    end
  end

endmodule
